// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and helpers for the nibble-serial add/subtract controller.
package nsas_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIBBLE_W = 4;

    // The slice inverts b again when cin=1, so pre-inverting by sub^carry
    // makes the slice's effective operand B (add) or ~B (sub) regardless of carry.
    function automatic logic [NIBBLE_W-1:0] encode_b(input logic [NIBBLE_W-1:0] nib,
                                                     input logic sub,
                                                     input logic carry);
        return nib ^ {NIBBLE_W{sub ^ carry}};
    endfunction

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// Request/response bus of nibble_serial_addsub; in_acc exists only with NSAS_ACCUM_EN.
interface nibble_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
`ifdef NSAS_ACCUM_EN
    logic             in_acc;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
`ifdef NSAS_ACCUM_EN
        output in_acc,
`endif
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
`ifdef NSAS_ACCUM_EN
        input  in_acc,
`endif
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

endinterface

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/subtract computed one nibble per cycle through an external 4-bit slice.
// Define NSAS_ACCUM_EN to allow operand A to be taken from the previous result.
module nibble_serial_addsub
    import nsas_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    nibble_serial_addsub_if.slave bus,
    output logic [NIBBLE_W-1:0] slice_a,
    output logic [NIBBLE_W-1:0] slice_b,
    output logic                slice_cin,
    input  logic [NIBBLE_W-1:0] slice_s,
    input  logic                slice_cout,
    input  logic                slice_c3
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sub_q, sub_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   res;
    logic               last;

    assign last = (idx_q == IDX_W'(NIB - 1));

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        valid_d = valid_q;
        res     = sum_q;
        res[NIBBLE_W*idx_q +: NIBBLE_W] = slice_s;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d = bus.in_a;
`ifdef NSAS_ACCUM_EN
                    if (bus.in_acc) a_d = sum_q;
`endif
                    b_d     = bus.in_b;
                    sub_d   = bus.in_sub;
                    carry_d = bus.in_sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = res;
                carry_d = slice_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (last) begin
                    cout_d  = slice_cout;
                    ovf_d   = slice_cout ^ slice_c3;
                    zero_d  = (res == '0);
                    valid_d = 1'b1;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    // Slice inputs come only from registers and are parked at zero outside RUN.
    always_comb begin
        slice_a   = '0;
        slice_b   = '0;
        slice_cin = 1'b0;
        if (state_q == RUN) begin
            slice_a   = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
            slice_b   = encode_b(b_q[NIBBLE_W*idx_q +: NIBBLE_W], sub_q, carry_q);
            slice_cin = carry_q;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_zero  = zero_q;

endmodule
